// File: rtl/skew_buffer.sv
// skew_buffer: per-lane diagonal delay stage feeding (skew) or draining (deskew) a systolic array.
// Define SKEW_BUFFER_DESKEW_EN to enable the deskew mode; otherwise only skew delays are built.
module skew_buffer #(
    parameter int N  = 8,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic            in_last,
    input  logic            stall,
    input  logic            mode,
    output logic [N*DW-1:0] out_data,
    output logic [N-1:0]    out_lane_valid,
    output logic            out_last,
    output logic            busy
);
    localparam int CD = N - 1;

    logic         w_accept;
    logic         w_advance;
    logic         w_mode;
    logic         w_max_v;
    logic         w_last_tap;
    logic [N-1:0] w_lane_busy;
    logic [N-1:0] w_end_v;
    logic [CD-1:0] r_last;
    logic          r_out_last;

    assign w_accept  = in_valid & ~stall;
    assign w_advance = ~stall;
    assign busy      = |w_lane_busy;

`ifdef SKEW_BUFFER_DESKEW_EN
    localparam int SW = $clog2(N);
    logic r_mode;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
        end else if (w_accept && !busy) begin
            r_mode <= mode;
        end
    end

    // The beat that opens a new burst is already routed with the mode it brings.
    assign w_mode = (w_accept && !busy) ? mode : r_mode;
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;
    assign w_mode        = 1'b0;
`endif

    for (genvar i = 0; i < N; i++) begin : g_lane
`ifdef SKEW_BUFFER_DESKEW_EN
        localparam int DEPTH = CD;
`else
        localparam int DEPTH = i;
`endif
        logic          w_in_v;
        logic          w_tap_v;
        logic [DW-1:0] w_in_d;
        logic [DW-1:0] w_tap_d;
        logic          r_out_v;
        logic [DW-1:0] r_out_d;

        assign w_in_v = w_accept;
        assign w_in_d = w_accept ? in_data[i*DW +: DW] : '0;

        if (DEPTH == 0) begin : g_direct
            assign w_tap_v        = w_in_v;
            assign w_tap_d        = w_in_d;
            assign w_lane_busy[i] = 1'b0;
            assign w_end_v[i]     = 1'b0;
        end else begin : g_chain
            logic [DEPTH-1:0]         r_v;
            logic [DEPTH-1:0][DW-1:0] r_d;

            // NOTE: the chain data is cleared on reset too, so a discarded tile leaves no stale bytes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= '0;
                    r_d <= '0;
                end else if (w_advance) begin
                    r_v[0] <= w_in_v;
                    r_d[0] <= w_in_d;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_v[k] <= r_v[k-1];
                        r_d[k] <= r_d[k-1];
                    end
                end
            end

`ifdef SKEW_BUFFER_DESKEW_EN
            logic [SW-1:0] w_sel;
            assign w_sel = w_mode ? SW'(N - 1 - i) : SW'(i);

            // NOTE: defaults first so the tap mux cannot infer a latch.
            always_comb begin
                w_tap_v = w_in_v;
                w_tap_d = w_in_d;
                for (int k = 1; k <= DEPTH; k++) begin
                    if (w_sel == SW'(k)) begin
                        w_tap_v = r_v[k-1];
                        w_tap_d = r_d[k-1];
                    end
                end
            end
`else
            assign w_tap_v = r_v[DEPTH-1];
            assign w_tap_d = r_d[DEPTH-1];
`endif
            assign w_lane_busy[i] = |r_v;
            assign w_end_v[i]     = r_v[DEPTH-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out_v <= 1'b0;
                r_out_d <= '0;
            end else if (w_advance) begin
                r_out_v <= w_tap_v;
                r_out_d <= w_tap_v ? w_tap_d : '0;
            end
        end

        assign out_data[i*DW +: DW] = r_out_d;
        assign out_lane_valid[i]    = r_out_v;
    end

    // Tile-end marker travels the maximum delay and qualifies with the slowest lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= '0;
            r_out_last <= 1'b0;
        end else if (w_advance) begin
            r_last[0] <= w_accept & in_last;
            for (int k = 1; k < CD; k++) begin
                r_last[k] <= r_last[k-1];
            end
            r_out_last <= w_last_tap & w_max_v;
        end
    end

    assign w_last_tap = r_last[CD-1];
    assign w_max_v    = w_mode ? w_end_v[0] : w_end_v[N-1];
    assign out_last   = r_out_last;

endmodule
